segmem: RTL

Parametrised segmented data memory with NSEG independent segments, each owning one request channel. Each channel has a valid/ready request handshake, a registered read with a one-cycle response and an out-of-range error flag. After reset, or on command, a hardware clear sequencer zeroes every segment. The block serves as the processor's multi-segment storage, one channel per pipeline consumer.

---
 rtl/segmem_pkg.sv | 17 +
 rtl/segmem_bank.sv | 108 ++++++++++
 rtl/segmem.sv | 103 ++++++++++
 3 files changed

// File: rtl/segmem_pkg.sv
// Shared types and helpers for the segmented data memory.
// The parity helper is only used when SEGMEM_PARITY_EN is defined.
package segmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } seg_state_e;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned PAR_MAXW = 1024;

  function automatic logic even_parity(input logic [PAR_MAXW-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/segmem_bank.sv
// One memory segment: storage array, single write port, registered read with range check.
// Optional per-entry even parity when SEGMEM_PARITY_EN is defined.
module segmem_bank
  import segmem_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rsp_en_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    req_addr_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rd_o,
  output logic             rerr_o,
  output logic             perr_o
);

`ifdef SEGMEM_PARITY_EN
  localparam int unsigned EW = WIDTH + 1;
`else
  localparam int unsigned EW = WIDTH;
`endif

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    wr_word;
  logic [EW-1:0]    rd_word;
  logic             wr_in_rng;
  logic             req_in_rng;

  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             rerr_q, rerr_d;

  always_comb begin
    wr_in_rng  = ({1'b0, wr_addr_i} < DEPTH_W);
    req_in_rng = ({1'b0, req_addr_i} < DEPTH_W);
`ifdef SEGMEM_PARITY_EN
    wr_word = {even_parity(PAR_MAXW'(wr_data_i)), wr_data_i};
`else
    wr_word = wr_data_i;
`endif
  end

  // Storage is deliberately not reset; the clear sequencer initialises it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_rng) begin
      mem_q[wr_addr_i] <= wr_word;
    end
  end

  always_comb begin
    rd_word  = '0;
    if (rd_en_i && req_in_rng) begin
      rd_word = mem_q[req_addr_i];
    end
    rvalid_d = rsp_en_i;
    rerr_d   = rsp_en_i && !req_in_rng;
    rd_d     = rd_word[WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_q     <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rd_o     = rd_q;
  assign rerr_o   = rerr_q;

`ifdef SEGMEM_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = 1'b0;
    if (rd_en_i && req_in_rng) begin
      perr_d = (even_parity(PAR_MAXW'(rd_word[WIDTH-1:0])) != rd_word[WIDTH]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/segmem.sv
// Segmented data memory: NSEG independent banks, one request channel each, plus a clear sequencer.
// Build option: SEGMEM_PARITY_EN adds a stored even-parity bit per entry and drives perr.
module segmem
  import segmem_pkg::*;
#(
  parameter int unsigned NSEG  = 4,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic [NSEG-1:0]       req,
  input  logic [NSEG-1:0]       we,
  input  logic [NSEG*AW-1:0]    addr,
  input  logic [NSEG*WIDTH-1:0] wd,
  output logic [NSEG-1:0]       ready,
  output logic [NSEG-1:0]       rvalid,
  output logic [NSEG*WIDTH-1:0] rd,
  output logic [NSEG-1:0]       rerr,
  output logic [NSEG-1:0]       perr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  seg_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign busy  = (state_q == CLEAR);
  assign ready = {NSEG{~busy}};

  for (genvar c = 0; c < NSEG; c++) begin : g_bank
    logic             acc;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // While clearing, the sequencer owns the write port; requests cannot be accepted then.
    always_comb begin
      acc     = req[c] & ~busy;
      wr_en   = busy | (acc & we[c]);
      wr_addr = busy ? idx_q : addr[c*AW +: AW];
      wr_data = busy ? '0 : wd[c*WIDTH +: WIDTH];
    end

    segmem_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rsp_en_i   (acc),
      .rd_en_i    (acc & ~we[c]),
      .req_addr_i (addr[c*AW +: AW]),
      .rvalid_o   (rvalid[c]),
      .rd_o       (rd[c*WIDTH +: WIDTH]),
      .rerr_o     (rerr[c]),
      .perr_o     (perr[c])
    );
  end

endmodule
